// File: rtl/dmem_bytelane_sync.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_bytelane_sync
//  Purpose  : Single-port MIPS data memory with byte/half/word access,
//             little-endian byte lanes and sign/zero-extended loads.
//             - Synchronous read with a one-cycle rvalid strobe.
//             - Misaligned, reserved-size and out-of-range requests raise err.
//             - An optional post-reset sweep clears the array, which has no
//               reset of its own.
//  Ports    : clk, rst_n (async, active-low)
//             req/we/size/uns/addr/wdata : request channel
//             ready : accepting requests (FSM idle)
//             rvalid/rdata : load response; rdata is 0 when rvalid is low
//             err : illegal-request pulse, one cycle after acceptance
//             ld_cnt/st_cnt/err_cnt : only when DMEM_STATS_EN is defined
//  Options  : `define DMEM_STATS_EN adds the access counters.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_bytelane_sync #(
    parameter int DEPTH          = 32,
    parameter int ADDR_W         = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              rvalid,
    output logic [31:0]       rdata,
    output logic              err
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]       ld_cnt,
    output logic [31:0]       st_cnt,
    output logic [31:0]       err_cnt
`endif
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;
    localparam logic [0:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    logic [31:0]      mem [DEPTH];

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [IDX_W-1:0] r_clr_idx;

    logic             r_rvalid;
    logic             r_err;
    logic             r_ld_ok;
    logic [1:0]       r_size;
    logic             r_uns;
    logic [1:0]       r_lane;
    logic [31:0]      r_rword;

    logic             w_accept;
    logic             w_illegal;
    logic             w_wr;
    logic             w_rd;
    logic [IDX_W-1:0] w_idx;
    logic [3:0]       w_be;
    logic [31:0]      w_wd;
    logic [31:0]      w_sh;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_idx == LAST_IDX) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = (r_state == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_idx <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clr_idx <= (r_clr_idx == LAST_IDX) ? '0 : r_clr_idx + 1'b1;
        end
    end

    // ------------------------------------------------- request decode
    assign w_accept = req && ready;
    assign w_idx    = addr[IDX_W+1:2];

    // The range check uses the full word index, so high address bits that
    // do not reach the array still make the access illegal.
    always_comb begin
        w_illegal = 1'b0;
        if (size == 2'b11)                             w_illegal = 1'b1;
        if (size == 2'b01 && addr[0])                  w_illegal = 1'b1;
        if (size == 2'b10 && addr[1:0] != 2'b00)       w_illegal = 1'b1;
        if (64'(addr[ADDR_W-1:2]) >= 64'(DEPTH))       w_illegal = 1'b1;
    end

    assign w_wr = w_accept && we  && !w_illegal;
    assign w_rd = w_accept && !we && !w_illegal;

    // Store data is replicated across lanes; the byte enables pick the lanes.
    always_comb begin
        case (size)
            2'b00: begin
                w_be = 4'b0001 << addr[1:0];
                w_wd = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_be = addr[1] ? 4'b1100 : 4'b0011;
                w_wd = {2{wdata[15:0]}};
            end
            default: begin
                w_be = 4'b1111;
                w_wd = wdata;
            end
        endcase
    end

    // ------------------------------------------------------------ array
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            mem[r_clr_idx] <= '0;
        end else if (w_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
            end
        end
        if (w_rd) begin
            r_rword <= mem[w_idx];
        end
    end

    // ------------------------------------------------------ response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_ld_ok  <= 1'b0;
            r_size   <= 2'b00;
            r_uns    <= 1'b0;
            r_lane   <= 2'b00;
        end else begin
            r_rvalid <= w_accept && !we;
            r_err    <= w_accept && w_illegal;
            r_ld_ok  <= w_rd;
            if (w_rd) begin
                r_size <= size;
                r_uns  <= uns;
                r_lane <= addr[1:0];
            end
        end
    end

    // Lane extraction and extension happen after the registered word, so
    // rdata is forced to zero whenever no legal load is being returned.
    always_comb begin
        w_sh  = r_rword >> {r_lane, 3'b000};
        rdata = '0;
        if (r_ld_ok) begin
            case (r_size)
                2'b00:   rdata = r_uns ? {24'h0, w_sh[7:0]}  : {{24{w_sh[7]}},  w_sh[7:0]};
                2'b01:   rdata = r_uns ? {16'h0, w_sh[15:0]} : {{16{w_sh[15]}}, w_sh[15:0]};
                default: rdata = r_rword;
            endcase
        end
    end

    assign rvalid = r_rvalid;
    assign err    = r_err;

`ifdef DMEM_STATS_EN
    // ---------------------------------------------------- statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt  <= '0;
            st_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            if (w_rd)                  ld_cnt  <= ld_cnt + 32'd1;
            if (w_wr)                  st_cnt  <= st_cnt + 32'd1;
            if (w_accept && w_illegal) err_cnt <= err_cnt + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/dmem_bytelane_sync.md
Name: dmem_bytelane_sync

Overview:
Parametrised single-port data memory for the MIPS datapath. It is the successor to the word-only combinational-read data RAM.
- Adds byte, halfword and word access with little-endian byte lanes, plus sign or zero extension on loads.
- Read is synchronous, with a valid strobe.
- Alignment and range errors are flagged.
- A hardware clear sweep runs after reset, because the RAM array itself has no reset.
- Sits between the ALU/address stage and write-back; the core stalls on ready=0.

Parameters:
DEPTH, 32, number of 32-bit words (any value >= 2).
ADDR_W, 32, byte-address width.
CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = skip the sweep.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
req  in  1  access request, sampled only when ready=1.
we  in  1  1 = store, 0 = load.
size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
uns  in  1  load zero-extend (1) or sign-extend (0); ignored on stores.
addr  in  ADDR_W  byte address.
wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
ready  out  1  block accepts requests.
rvalid  out  1  one-cycle pulse, rdata valid.
rdata  out  32  extended load data.
err  out  1  one-cycle pulse, the previous accepted request was illegal.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - rvalid=0, rdata=0, err=0, clear index=0.
  - FSM=CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - ready = (FSM==IDLE), so ready resets to !CLEAR_ON_RESET.
- FSM:
  - CLEAR: writes 0 to word[idx] each cycle, idx++. After idx==DEPTH-1 is written -> IDLE. Takes exactly DEPTH cycles; ready=0 throughout; req ignored.
  - IDLE: ready=1; requests are accepted. No other states.
- Reset asserted mid-sweep: aborts the sweep. After release the sweep restarts from idx 0.
- Word index = addr[ADDR_W-1:2]; lane = addr[1:0].
- Illegal accepted request (any one of the following):
  - size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - word index >= DEPTH.
  Response to an illegal request: no array write; err=1 in the following cycle. For a load, rvalid=1 with rdata=0 in that same cycle.
- Store (legal): the array is updated at the accepting edge.
  - byte: wdata[7:0] written to lane addr[1:0].
  - half: wdata[15:0] written to lanes {addr[1],0}+1 : {addr[1],0}.
  - word: all lanes written.
  - Unwritten lanes are preserved.
  - No rvalid is generated.
- Load (legal): latency 1.
  - Accepting edge N; rvalid=1 and rdata valid during cycle N+1.
  - rvalid and rdata hold for one cycle only; rdata returns to 0 when rvalid=0.
  - Selected lane(s) extended per uns.
- Back-to-back: one request per cycle is accepted, with no bubbles.
  - A load immediately after a store to the same word returns the new data.
  - A single request is either a load or a store, so a same-cycle read/write conflict cannot occur.
- addr bits above the index width are used only in the range check.

Optional Feature:
DMEM_STATS_EN:
- Defined: adds outputs ld_cnt[31:0], st_cnt[31:0], err_cnt[31:0].
  - Each counter increments by 1 per accepted legal load, legal store, or illegal request respectively.
  - Counters reset to 0 on rst_n and wrap at 2^32.
  - Counters do not count while FSM=CLEAR.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
1. Default params, release rst_n.
   -> ready=0 for exactly 32 cycles, then 1.
   -> Word loads at addr 0x00..0x7C all return 0x00000000.
2. Store word 0xDEADBEEF @0x10, then byte 0x7F @0x11.
   -> Word load @0x10 = 0xDEAD7FEF, rvalid one cycle after req.
3. With word @0x10 = 0xDEAD7FEF:
   -> load byte @0x13 signed = 0xFFFFFFDE;
   -> load byte @0x13 unsigned = 0x000000DE;
   -> load half @0x12 signed = 0xFFFFDEAD.
4. Illegal requests:
   -> word load @0x12: err=1, rvalid=1, rdata=0;
   -> half store @0x21: err=1, memory unchanged;
   -> word access @0x80 with DEPTH=32: err=1.
5. Assert rst_n low at clear cycle 10, release.
   -> Sweep restarts and ready rises exactly 32 cycles after release.
   -> A req issued during the sweep has no effect.
6. With DMEM_STATS_EN, issue 3 loads, 2 stores, 1 misaligned request.
   -> ld_cnt=3, st_cnt=2, err_cnt=1.
